// File: rtl/ir_tx.sv
// ir_tx: NEC-format IR transmitter (send side of the ir_rx link).
// Frame: lead mark, lead space, 32 data bits MSB first (mark + space whose
// length encodes the bit), stop mark, then a minimum idle gap before o_done.
// o_ir_txb is active-low: 0 = mark (LED on), 1 = space/idle.
//
// Optional build macro: IR_TX_CARRIER_EN
//   defined   - marks are modulated with a carrier (high for the first
//               CARRIER_DIV/3 clks of every CARRIER_DIV period), phase
//               restarting at the first clk of every mark state.
//   undefined - baseband envelope only; no carrier counter is built.
// State timing is identical in both builds.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line idle (1), waiting for i_start
// LEAD_M | lead mark (0), T_LEAD_MARK us
// LEAD_S | lead space (1), T_LEAD_SPACE us
// BIT_M  | data bit mark (0), T_BIT_MARK us
// BIT_S  | data bit space (1), T_ONE_SPACE or T_ZERO_SPACE by sh[31]
// STOP_M | stop mark (0), T_BIT_MARK us
// GAP    | inter-frame idle (1), T_GAP us; o_done on its last clk
module ir_tx #(
  parameter int CLK_DIV      = 50,
  parameter int T_LEAD_MARK  = 9000,
  parameter int T_LEAD_SPACE = 4500,
  parameter int T_BIT_MARK   = 560,
  parameter int T_ZERO_SPACE = 560,
  parameter int T_ONE_SPACE  = 1690,
  parameter int T_GAP        = 40000
`ifdef IR_TX_CARRIER_EN
  ,
  parameter int CARRIER_DIV  = 1316
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_data,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ir_txb
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEAD_M = 3'd1,
    S_LEAD_S = 3'd2,
    S_BIT_M  = 3'd3,
    S_BIT_S  = 3'd4,
    S_STOP_M = 3'd5,
    S_GAP    = 3'd6
  } state_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Last us_cnt value of each segment: a segment of T us ends on the tick
  // where us_cnt == T-1.
  localparam logic [16:0] LEAD_M_LAST = 17'(T_LEAD_MARK - 1);
  localparam logic [16:0] LEAD_S_LAST = 17'(T_LEAD_SPACE - 1);
  localparam logic [16:0] MARK_LAST   = 17'(T_BIT_MARK - 1);
  localparam logic [16:0] ZERO_LAST   = 17'(T_ZERO_SPACE - 1);
  localparam logic [16:0] ONE_LAST    = 17'(T_ONE_SPACE - 1);
  localparam logic [16:0] GAP_LAST    = 17'(T_GAP - 1);

  state_t           state_q, state_d;
  logic [31:0]      sh_q, sh_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [16:0]      us_cnt_q, us_cnt_d;
  logic             ir_txb_q, ir_txb_d;

  logic             tick;
  logic             seg_end;
  logic [16:0]      seg_last;
  logic             mark_d;

  // Prescaler tick and the terminal count of the segment currently running.
  always_comb begin
    tick     = (div_cnt_q == DIV_LAST);
    seg_last = '0;
    case (state_q)
      S_LEAD_M: seg_last = LEAD_M_LAST;
      S_LEAD_S: seg_last = LEAD_S_LAST;
      S_BIT_M:  seg_last = MARK_LAST;
      S_BIT_S:  seg_last = sh_q[31] ? ONE_LAST : ZERO_LAST;
      S_STOP_M: seg_last = MARK_LAST;
      S_GAP:    seg_last = GAP_LAST;
      default:  seg_last = '0;
    endcase
    seg_end = tick && (us_cnt_q == seg_last);
  end

  // Next-state logic; the shift register and bit index advance at the end
  // of each data-bit space.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LEAD_M;
          sh_d    = i_data;
        end
      end
      S_LEAD_M: begin
        if (seg_end) state_d = S_LEAD_S;
      end
      S_LEAD_S: begin
        if (seg_end) begin
          state_d   = S_BIT_M;
          bit_idx_d = '0;
        end
      end
      S_BIT_M: begin
        if (seg_end) state_d = S_BIT_S;
      end
      S_BIT_S: begin
        if (seg_end) begin
          sh_d = {sh_q[30:0], 1'b0};
          if (bit_idx_q == 5'd31) begin
            // Hold the index at 31 so it never wraps inside the frame.
            state_d = S_STOP_M;
          end else begin
            state_d   = S_BIT_M;
            bit_idx_d = bit_idx_q + 5'd1;
          end
        end
      end
      S_STOP_M: begin
        if (seg_end) state_d = S_GAP;
      end
      S_GAP: begin
        if (seg_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tick prescaler and per-state us counter. The prescaler is held clear in
  // IDLE, so it starts from zero at accept; since every segment ends on a
  // tick, it is also at zero at the start of every later state.
  always_comb begin
    div_cnt_d = div_cnt_q;
    us_cnt_d  = us_cnt_q;
    if (state_q == S_IDLE) begin
      div_cnt_d = '0;
      us_cnt_d  = '0;
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      if (state_d != state_q) begin
        us_cnt_d = '0;
      end else if (tick) begin
        us_cnt_d = us_cnt_q + 17'd1;
      end
    end
  end

  assign mark_d = (state_d == S_LEAD_M) || (state_d == S_BIT_M) ||
                  (state_d == S_STOP_M);

`ifdef IR_TX_CARRIER_EN
  localparam int CAR_W = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(CARRIER_DIV - 1);
  localparam logic [CAR_W-1:0] CAR_HIGH = CAR_W'(CARRIER_DIV / 3);

  logic [CAR_W-1:0] car_cnt_q, car_cnt_d;

  // Carrier phase counter: restarts on entry to every mark, parked at zero
  // otherwise; the line is computed from next-state values so it is
  // registered in step with the state.
  always_comb begin
    if (!mark_d || (state_d != state_q) || (car_cnt_q == CAR_LAST)) begin
      car_cnt_d = '0;
    end else begin
      car_cnt_d = car_cnt_q + 1'b1;
    end
    ir_txb_d = ~(mark_d && (car_cnt_d < CAR_HIGH));
  end

  // Carrier counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) car_cnt_q <= '0;
    else     car_cnt_q <= car_cnt_d;
  end
`else
  // Baseband line level follows the next state so it is registered in step.
  always_comb begin
    ir_txb_d = ~mark_d;
  end
`endif

  // State, datapath and line registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      bit_idx_q <= '0;
      div_cnt_q <= '0;
      us_cnt_q  <= '0;
      ir_txb_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_idx_q <= bit_idx_d;
      div_cnt_q <= div_cnt_d;
      us_cnt_q  <= us_cnt_d;
      ir_txb_q  <= ir_txb_d;
    end
  end

  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = (state_q == S_GAP) && seg_end;
  assign o_ir_txb = ir_txb_q;

endmodule

// File: tb/tb_ir_tx.sv
// tb_ir_tx: scoreboard bench for ir_tx with shortened timing parameters.
// Stimulus pushes the expected line segments (level, length in clks) and
// o_done events of every frame; a monitor measures the line and pops.
module tb_ir_tx;

  localparam int CLK_DIV      = 3;
  localparam int T_LEAD_MARK  = 9;
  localparam int T_LEAD_SPACE = 5;
  localparam int T_BIT_MARK   = 2;
  localparam int T_ZERO_SPACE = 2;
  localparam int T_ONE_SPACE  = 5;
  localparam int T_GAP        = 12;
  localparam int G            = T_GAP * CLK_DIV;

  localparam int K_SEG  = 0;
  localparam int K_DONE = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_data = '0;
  logic        i_start = 1'b0;
  logic        o_busy;
  logic        o_done;
  logic        o_ir_txb;

  always #5 clk = ~clk;

  ir_tx #(
    .CLK_DIV     (CLK_DIV),
    .T_LEAD_MARK (T_LEAD_MARK),
    .T_LEAD_SPACE(T_LEAD_SPACE),
    .T_BIT_MARK  (T_BIT_MARK),
    .T_ZERO_SPACE(T_ZERO_SPACE),
    .T_ONE_SPACE (T_ONE_SPACE),
    .T_GAP       (T_GAP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_start (i_start),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_ir_txb(o_ir_txb)
  );

  typedef struct {
    int kind;
    int level;
    int len;
    bit exact;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int level, input int len, input bit exact);
    exp_t e;
    e.kind  = kind;
    e.level = level;
    e.len   = len;
    e.exact = exact;
    exp_q.push_back(e);
  endtask

  // Expected line of one frame, starting with the idle run it ends.
  task automatic push_frame(input logic [31:0] d, input int idle_len, input bit idle_exact);
    push(K_SEG, 1, idle_len, idle_exact);
    push(K_SEG, 0, T_LEAD_MARK * CLK_DIV, 1'b1);
    push(K_SEG, 1, T_LEAD_SPACE * CLK_DIV, 1'b1);
    for (int i = 31; i >= 0; i--) begin
      push(K_SEG, 0, T_BIT_MARK * CLK_DIV, 1'b1);
      push(K_SEG, 1, (d[i] ? T_ONE_SPACE : T_ZERO_SPACE) * CLK_DIV, 1'b1);
    end
    push(K_SEG, 0, T_BIT_MARK * CLK_DIV, 1'b1);
    push(K_DONE, 1, G, 1'b1);
  endtask

  task automatic check_event(input string what, input int kind, input int level, input int len);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got kind=%0d level=%0d len=%0d, expected nothing queued",
               what, kind, level, len);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.level != level || (e.exact ? (len != e.len) : (len < e.len))) begin
      errors++;
      $display("FAIL %s: got kind=%0d level=%0d len=%0d, expected kind=%0d level=%0d len%s%0d",
               what, kind, level, len, e.kind, e.level, e.exact ? "==" : ">=", e.len);
    end
  endtask

  // Monitor: measures line runs and o_done at the falling clock edge.
  int   run = 0;
  logic prev = 1'b1;
  bit   after_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      run        = 0;
      prev       = 1'b1;
      after_done = 1'b0;
    end else begin
      if (after_done) begin
        chk("busy_after_done", int'(o_busy), 0);
        after_done = 1'b0;
      end
      if (o_ir_txb !== prev) begin
        check_event("segment", K_SEG, int'(prev), run);
        if (o_ir_txb == 1'b0) chk("busy_in_mark", int'(o_busy), 1);
        prev = o_ir_txb;
        run  = 1;
      end else begin
        run++;
      end
      if (o_done) begin
        check_event("done", K_DONE, int'(o_ir_txb), run);
        after_done = 1'b1;
        done_seen++;
      end
    end
  end

  task automatic send(input logic [31:0] d);
    @(negedge clk);
    i_data  = d;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_data  = ~d;
  endtask

  task automatic wait_dones(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done_seen >= target) break;
    end
    if (done_seen < target) begin
      chk("done_timeout", done_seen, target);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txb", int'(o_ir_txb), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    rst = 1'b0;

    // Reset in the middle of the lead mark abandons the frame.
    push(K_SEG, 1, 1, 1'b0);
    send(32'hDEAD_BEEF);
    repeat (7) @(negedge clk);
    chk("pre_rst_mark", int'(o_ir_txb), 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_txb", int'(o_ir_txb), 1);
    chk("async_rst_busy", int'(o_busy), 0);
    repeat (2) @(negedge clk);
    chk("rst_queue_empty", exp_q.size(), 0);
    rst = 1'b0;

    // Fresh full frames with distinct codes.
    push_frame(32'h00FF_A55A, 1, 1'b0);
    send(32'h00FF_A55A);
    wait_dones(1, 3000);

    push_frame(32'h0000_0000, G + 1, 1'b0);
    send(32'h0000_0000);
    wait_dones(2, 3000);

    push_frame(32'hFFFF_FFFF, G + 1, 1'b0);
    send(32'hFFFF_FFFF);
    wait_dones(3, 3000);

    // Second start mid-frame with different data is ignored.
    push_frame(32'hA5A5_0F0F, G + 1, 1'b0);
    send(32'hA5A5_0F0F);
    repeat (150) @(negedge clk);
    chk("busy_mid_frame", int'(o_busy), 1);
    i_data  = 32'h1234_5678;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_dones(4, 3000);

    // i_start held high: frames back to back, lead mark 2 clks after o_done.
    push_frame(32'hC3C3_3C3C, G + 1, 1'b0);
    push_frame(32'hC3C3_3C3C, G + 1, 1'b1);
    push_frame(32'hC3C3_3C3C, G + 1, 1'b1);
    @(negedge clk);
    i_data  = 32'hC3C3_3C3C;
    i_start = 1'b1;
    wait_dones(7, 9000);
    i_start = 1'b0;

    repeat (3 * G) @(negedge clk);
    chk("final_done_count", done_seen, 7);
    chk("final_busy", int'(o_busy), 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
